// File: rtl/ifid_pipe.sv
// ifid_pipe: two-entry skid buffer between fetch and decode with flush and saturating discard count.
module ifid_pipe #(
    parameter int          XLEN    = 64,
    parameter logic [31:0] NOP_INS = 32'h00000013
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_pre_valid,
    output logic            o_pre_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_ins,
    output logic            o_post_valid,
    input  logic            i_post_ready,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_ins,
    output logic [31:0]     o_flush_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t          state_q;
    logic [XLEN-1:0] main_pc_q, skid_pc_q;
    logic [31:0]     main_ins_q, skid_ins_q, flush_cnt_q, flush_cnt_d;
    logic            push, pop;
    logic [1:0]      held, disc;
    logic [32:0]     sum;
    assign o_pre_ready  = (state_q != TWO) & ~i_flush;
    assign o_post_valid = (state_q != EMPTY);
    assign o_pc         = main_pc_q;
    assign o_ins        = main_ins_q;
    assign o_flush_cnt  = flush_cnt_q;
    assign push         = i_pre_valid & o_pre_ready;
    assign pop          = o_post_valid & i_post_ready;
    // a pop in the flush cycle completes, so it is not counted as discarded
    always_comb begin
        held        = state_q == TWO ? 2'd2 : state_q == ONE ? 2'd1 : 2'd0;
        disc        = held - {1'b0, pop};
        sum         = {1'b0, flush_cnt_q} + {31'b0, disc};
        flush_cnt_d = sum[32] ? '1 : sum[31:0];
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= EMPTY;
            main_pc_q   <= '0;
            main_ins_q  <= NOP_INS;
            skid_pc_q   <= '0;
            skid_ins_q  <= NOP_INS;
            flush_cnt_q <= '0;
        end else if (i_flush) begin
            state_q     <= EMPTY;
            main_ins_q  <= NOP_INS;
            flush_cnt_q <= flush_cnt_d;
        end else begin
            case (state_q)
                EMPTY: if (push) begin
                    state_q    <= ONE;
                    main_pc_q  <= i_pc;
                    main_ins_q <= i_ins;
                end
                ONE: if (push && pop) begin
                    main_pc_q  <= i_pc;
                    main_ins_q <= i_ins;
                end else if (push) begin
                    state_q    <= TWO;
                    skid_pc_q  <= i_pc;
                    skid_ins_q <= i_ins;
                end else if (pop) begin
                    state_q    <= EMPTY;
                    main_ins_q <= NOP_INS;
                end
                TWO: if (pop) begin
                    state_q    <= ONE;
                    main_pc_q  <= skid_pc_q;
                    main_ins_q <= skid_ins_q;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_ifid_pipe.sv
// tb_ifid_pipe: directed checks of streaming, backpressure, flush counting, saturation and reset.
module tb_ifid_pipe;
    localparam logic [31:0] NOP = 32'h00000013;
    logic        i_clk = 0, i_rst = 1, i_flush = 0, i_pre_valid = 0, i_post_ready = 0;
    logic [63:0] i_pc = '0;
    logic [31:0] i_ins = '0;
    logic        o_pre_ready, o_post_valid;
    logic [63:0] o_pc;
    logic [31:0] o_ins, o_flush_cnt;
    int errors = 0, checks = 0;

    ifid_pipe dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_pre_valid(i_pre_valid),
        .o_pre_ready(o_pre_ready), .i_pc(i_pc), .i_ins(i_ins), .o_post_valid(o_post_valid),
        .i_post_ready(i_post_ready), .o_pc(o_pc), .o_ins(o_ins), .o_flush_cnt(o_flush_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic fill_two(input logic [63:0] a, input logic [63:0] b);
        i_post_ready = 0;
        i_pre_valid  = 1;
        i_pc = a; i_ins = a[31:0] ^ 32'hA5A5_0000;
        step();
        i_pc = b; i_ins = b[31:0] ^ 32'hA5A5_0000;
        step();
        i_pre_valid = 0;
    endtask

    task automatic test_reset();
        i_rst = 1;
        step();
        step();
        checks++; if (o_post_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_post_valid); end
        checks++; if (o_pc !== 64'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", o_pc); end
        checks++; if (o_ins !== NOP) begin errors++; $display("FAIL reset_ins got %h exp %h", o_ins, NOP); end
        checks++; if (o_flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h exp 0", o_flush_cnt); end
        checks++; if (o_pre_ready !== 1'b1) begin errors++; $display("FAIL reset_pre_ready got %b exp 1", o_pre_ready); end
        i_rst = 0;
    endtask

    task automatic test_streaming();
        logic [63:0] pcs [3];
        pcs[0] = 64'h8000_0000; pcs[1] = 64'h8000_0004; pcs[2] = 64'h8000_0008;
        i_post_ready = 1;
        i_pre_valid  = 1;
        for (int k = 0; k < 3; k++) begin
            i_pc = pcs[k]; i_ins = 32'h100 + k;
            #1;
            checks++; if (o_pre_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b exp 1", k, o_pre_ready); end
            step();
            checks++; if (o_post_valid !== 1'b1 || o_pc !== pcs[k] || o_ins !== 32'h100 + k)
                begin errors++; $display("FAIL stream_out[%0d] got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h", k, o_post_valid, o_pc, o_ins, pcs[k], 32'h100 + k); end
        end
        i_pre_valid = 0;
        step();
        checks++; if (o_post_valid !== 1'b0 || o_ins !== NOP) begin errors++; $display("FAIL stream_drain got v=%b ins=%h exp v=0 ins=%h", o_post_valid, o_ins, NOP); end
    endtask

    task automatic test_backpressure();
        fill_two(64'h1000, 64'h2000);
        checks++; if (o_pre_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b exp 0", o_pre_ready); end
        step();
        checks++; if (o_pc !== 64'h1000 || o_ins !== 32'hA5A5_1000) begin errors++; $display("FAIL bp_hold got pc=%h ins=%h exp pc=1000 ins=a5a51000", o_pc, o_ins); end
        i_post_ready = 1;
        step();
        checks++; if (o_pc !== 64'h2000 || o_ins !== 32'hA5A5_2000) begin errors++; $display("FAIL bp_second got pc=%h ins=%h exp pc=2000 ins=a5a52000", o_pc, o_ins); end
        checks++; if (o_pre_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b exp 1", o_pre_ready); end
        step();
        checks++; if (o_post_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", o_post_valid); end
    endtask

    task automatic test_flush();
        fill_two(64'h3000, 64'h3004);
        i_flush = 1;
        step();
        i_flush = 0;
        checks++; if (o_post_valid !== 1'b0 || o_ins !== NOP) begin errors++; $display("FAIL flush_two_out got v=%b ins=%h exp v=0 ins=%h", o_post_valid, o_ins, NOP); end
        checks++; if (o_flush_cnt !== 32'd2) begin errors++; $display("FAIL flush_two_cnt got %0d exp 2", o_flush_cnt); end
        fill_two(64'h4000, 64'h4004);
        i_flush = 1; i_post_ready = 1;
        step();
        i_flush = 0; i_post_ready = 0;
        checks++; if (o_flush_cnt !== 32'd3) begin errors++; $display("FAIL flush_pop_cnt got %0d exp 3", o_flush_cnt); end
        i_pre_valid = 1; i_pc = 64'h5000;
        step();
        i_pre_valid = 0; i_flush = 1;
        step();
        i_flush = 0;
        checks++; if (o_flush_cnt !== 32'd4 || o_post_valid !== 1'b0) begin errors++; $display("FAIL flush_one got cnt=%0d v=%b exp cnt=4 v=0", o_flush_cnt, o_post_valid); end
    endtask

    task automatic test_flush_empty();
        i_pre_valid = 1; i_flush = 1; i_pc = 64'h6000;
        #1;
        checks++; if (o_pre_ready !== 1'b0) begin errors++; $display("FAIL flush_empty_ready got %b exp 0", o_pre_ready); end
        step();
        i_pre_valid = 0; i_flush = 0;
        checks++; if (o_post_valid !== 1'b0 || o_flush_cnt !== 32'd4) begin errors++; $display("FAIL flush_empty got v=%b cnt=%0d exp v=0 cnt=4", o_post_valid, o_flush_cnt); end
    endtask

    task automatic test_saturation();
        fill_two(64'h7000, 64'h7004);
        force dut.flush_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.flush_cnt_q;
        i_flush = 1;
        step();
        i_flush = 0;
        checks++; if (o_flush_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_first got %h exp ffffffff", o_flush_cnt); end
        fill_two(64'h7100, 64'h7104);
        i_flush = 1;
        step();
        i_flush = 0;
        checks++; if (o_flush_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold got %h exp ffffffff", o_flush_cnt); end
    endtask

    task automatic test_reset_flush();
        fill_two(64'h8000, 64'h8004);
        i_rst = 1; i_flush = 1;
        step();
        checks++; if (o_post_valid !== 1'b0 || o_pc !== 64'd0 || o_flush_cnt !== 32'd0)
            begin errors++; $display("FAIL rst_flush got v=%b pc=%h cnt=%h exp v=0 pc=0 cnt=0", o_post_valid, o_pc, o_flush_cnt); end
        checks++; if (o_pre_ready !== 1'b0) begin errors++; $display("FAIL rst_flush_ready got %b exp 0", o_pre_ready); end
        i_rst = 0; i_flush = 0;
        #1;
        checks++; if (o_pre_ready !== 1'b1) begin errors++; $display("FAIL rst_after_ready got %b exp 1", o_pre_ready); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_flush_empty();
        test_saturation();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ifid_pipe.md
IFID_PIPE -- requirements
Module: ifid_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64, PC width in bits.
REQ-002 SHALL have parameter NOP_INS, default 32'h00000013, instruction value presented when no entry is held.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_flush  input  1  discard all held entries (redirect from execute).
REQ-006 i_pre_valid  input  1  fetch stage offers {i_pc, i_ins}.
REQ-007 o_pre_ready  output  1  buffer can accept this cycle.
REQ-008 i_pc  input  XLEN  fetched PC.
REQ-009 i_ins  input  32  fetched instruction.
REQ-010 o_post_valid  output  1  entry presented to decode.
REQ-011 i_post_ready  input  1  decode accepts this cycle.
REQ-012 o_pc  output  XLEN  PC of head entry.
REQ-013 o_ins  output  32  instruction of head entry.
REQ-014 o_flush_cnt  output  32  saturating count of entries discarded by flush.

Function
REQ-015 push = i_pre_valid & o_pre_ready; pop = o_post_valid & i_post_ready.
REQ-016 Storage: main register (head) plus skid register, each holding {pc, ins}; FSM states EMPTY, ONE, TWO.
REQ-017 o_pre_ready = (state != TWO) & ~i_flush; the only combinational input-to-output path.
REQ-018 o_post_valid = (state != EMPTY); o_pc/o_ins driven from main register only.
REQ-019 EMPTY: push -> ONE, main <= input; else stay EMPTY.
REQ-020 ONE: push & pop -> ONE, main <= input; push & ~pop -> TWO, skid <= input; ~push & pop -> EMPTY; neither -> hold.
REQ-021 TWO: pop -> ONE, main <= skid; ~pop -> hold; push cannot occur.
REQ-022 Latency: entry pushed into EMPTY appears on o_post_valid the next cycle; no same-cycle bypass.
REQ-023 Entries leave strictly in push order; none duplicated or dropped except by flush.
REQ-024 Held main/skid contents SHALL remain stable while o_post_valid & ~i_post_ready.
REQ-025 Flush: next state EMPTY from any state; a pop in the flush cycle still counts as a completed transfer.
REQ-026 Flush discards d = held entries minus pop (EMPTY 0; ONE 1-pop; TWO 2-pop); o_flush_cnt += d.
REQ-027 o_flush_cnt saturates at 32'hFFFFFFFF (e.g. FFFFFFFE + 2 -> FFFFFFFF), never wraps.
REQ-028 On entering EMPTY, main register ins SHALL be loaded with NOP_INS so o_ins = NOP_INS whenever o_post_valid = 0.

Reset
REQ-029 i_rst sampled at rising edge: state <= EMPTY, main/skid pc <= 0, ins <= NOP_INS, o_flush_cnt <= 0.
REQ-030 During reset cycles: o_post_valid = 0, o_pc = 0, o_ins = NOP_INS; o_pre_ready follows REQ-017 on current state.
REQ-031 Reset mid-operation discards held entries without incrementing o_flush_cnt; reset has priority over flush.

Verification
REQ-032 Streaming: i_post_ready=1, push pc 0x80000000/0x80000004/0x80000008 on consecutive cycles -> same sequence on o_pc one cycle later, o_pre_ready stays 1, state never TWO.
REQ-033 Backpressure: i_post_ready=0, push A then B -> o_pre_ready=0 after 2nd push, o_pc=A held; raise i_post_ready -> A then B, o_pre_ready=1 after A pops.
REQ-034 Flush in TWO without pop -> next cycle o_post_valid=0, o_ins=0x00000013, o_flush_cnt=2; with pop in same cycle -> o_flush_cnt=1.
REQ-035 Flush with i_pre_valid=1 in EMPTY -> o_pre_ready=0 that cycle, nothing enters, o_flush_cnt unchanged.
REQ-036 Saturation: force o_flush_cnt to 0xFFFFFFFE, flush in TWO -> 0xFFFFFFFF; further flush keeps 0xFFFFFFFF.
REQ-037 Reset while TWO with i_flush=1 -> state EMPTY, o_pc=0, o_flush_cnt=0.
